// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux select arbiter.
package mux_arb_pkg;

   // Arbiter FSM: no owner, or one owner holding the data path.
   typedef enum logic [0:0] {
      StIdle    = 1'b0,
      StGranted = 1'b1
   } arb_state_e;

   // Number of requesters addressed by a select of the given width.
   function automatic int unsigned num_req(input int unsigned sel_width);
      return 32'd1 << sel_width;
   endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface mux_select_arbiter_if #(
   parameter int unsigned SEL_WIDTH = 2
) ();
   import mux_arb_pkg::*;

   localparam int unsigned N = num_req(SEL_WIDTH);

   logic [N-1:0]         req;
   logic [N-1:0]         done;
   logic [SEL_WIDTH-1:0] control_signals;
   logic [N-1:0]         grant;
   logic                 grant_valid;

   modport master (
      output req,
      output done,
      input  control_signals,
      input  grant,
      input  grant_valid
   );

   modport slave (
      input  req,
      input  done,
      output control_signals,
      output grant,
      output grant_valid
   );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping, so
// the requester at 'last' has the lowest priority.
module rr_priority_picker
   import mux_arb_pkg::*;
#(
   parameter int unsigned SEL_WIDTH = 2
) (
   input  logic [num_req(SEL_WIDTH)-1:0] req,
   input  logic [SEL_WIDTH-1:0]          last,
   output logic [SEL_WIDTH-1:0]          winner,
   output logic                          any_valid
);

   localparam int unsigned N = num_req(SEL_WIDTH);

   logic [SEL_WIDTH-1:0] idx;

   // First set request bit after 'last', wrapping modulo N (N is a power of two).
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = last + SEL_WIDTH'(i);
         if (!any_valid && req[idx]) begin
            winner    = idx;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter producing a registered select bus for the downstream
// multiplexer. Optional hold timeout is compiled in with ARB_TIMEOUT_EN.
module mux_select_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned SEL_WIDTH   = 2,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   mux_select_arbiter_if.slave bus
);

   localparam int unsigned N = num_req(SEL_WIDTH);

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65536) begin : gen_bad_hold
      $error("HOLD_CYCLES must lie in 1..65536");
   end

   arb_state_e           state_q;
   logic [SEL_WIDTH-1:0] last_q;
   logic [SEL_WIDTH-1:0] sel_q;
   logic [N-1:0]         grant_q;
   logic                 valid_q;

   logic [N-1:0]         owner_mask;
   logic                 owner_done;
   logic                 owner_req;
   logic                 timeout_hit;
   logic                 release_own;
   logic [N-1:0]         pick_req;
   logic [SEL_WIDTH-1:0] pick_winner;
   logic                 pick_valid;
   logic                 take_grant;

   // last_q doubles as the owner index while granted.
   assign owner_mask = N'(1) << last_q;
   assign owner_done = bus.done[last_q];
   assign owner_req  = bus.req[last_q];

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES - 1);

   logic [CntW-1:0] hold_cnt_q;

   assign timeout_hit = (hold_cnt_q == CntMax);

   // Cycles the current owner has held the grant beyond its first, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else if (take_grant) begin
         hold_cnt_q <= '0;
      end else if (state_q == StGranted && hold_cnt_q != CntMax) begin
         hold_cnt_q <= hold_cnt_q + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign release_own = (state_q == StGranted) && (owner_done || !owner_req || timeout_hit);

   // A timed-out owner keeps its request but loses priority via 'last'; an owner
   // signalling done is removed so it cannot win again on the same edge.
   always_comb begin
      pick_req = bus.req;
      if (state_q == StGranted && owner_done) begin
         pick_req = bus.req & ~owner_mask;
      end
   end

   rr_priority_picker #(
      .SEL_WIDTH (SEL_WIDTH)
   ) u_picker (
      .req       (pick_req),
      .last      (last_q),
      .winner    (pick_winner),
      .any_valid (pick_valid)
   );

   assign take_grant = pick_valid && ((state_q == StIdle) || release_own);

   // Arbitration FSM with registered select/grant outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         last_q  <= SEL_WIDTH'(N - 1);
         sel_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (take_grant) begin
                  state_q <= StGranted;
                  last_q  <= pick_winner;
                  sel_q   <= pick_winner;
                  grant_q <= N'(1) << pick_winner;
                  valid_q <= 1'b1;
               end
            end
            StGranted: begin
               if (take_grant) begin
                  last_q  <= pick_winner;
                  sel_q   <= pick_winner;
                  grant_q <= N'(1) << pick_winner;
                  valid_q <= 1'b1;
               end else if (release_own) begin
                  // select keeps pointing at the last owner
                  state_q <= StIdle;
                  grant_q <= '0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.control_signals = sel_q;
   assign bus.grant           = grant_q;
   assign bus.grant_valid     = valid_q;

endmodule
